// File: rtl/mult_hilo_if.sv
// CPU-side bundle for the HI/LO multiply controller.
// master = CPU execute/stall logic, slave = mult_hilo_ctrl.
//   start/is_signed/a/b : multiply launch request and operands
//   hi_we/lo_we/wdata   : MTHI/MTLO writes
//   busy/done           : stall and completion handshake
//   hi/lo               : architectural HI/LO read ports
interface mult_hilo_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// MULT/MULTU sequencing and HI/LO result stage.
// Converts signed operands to magnitudes for an external pipelined unsigned
// multiplier, waits MUL_LAT edges, then writes the (re-signed) product to HI/LO.
// Ports:
//   clk, reset (async, active-low)
//   bus   : mult_hilo_if.slave (launch, MTHI/MTLO, busy/done, HI/LO)
//   mul_a, mul_b : registered operand magnitudes to the multiplier
//   mul_z : 64-bit unsigned product from the multiplier
module mult_hilo_ctrl #(
  parameter int unsigned MUL_LAT = 6
) (
  input  logic        clk,
  input  logic        reset,
  mult_hilo_if.slave  bus,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               busy_q, done_q;
  logic [31:0]        hi_q, lo_q;

  logic               launch_c, capture_c;
  logic [31:0]        mag_a_c, mag_b_c;
  logic               neg_c;
  logic [63:0]        prod_c;

  // Operand magnitudes; -0x80000000 naturally yields 0x80000000 unsigned.
  assign mag_a_c = (bus.is_signed & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign mag_b_c = (bus.is_signed & bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
  assign neg_c   = bus.is_signed & (bus.a[31] ^ bus.b[31]);
  assign prod_c  = neg_q ? (~mul_z + 64'd1) : mul_z;

  // Next-state and launch/capture decode.
  always_comb begin
    state_d   = state_q;
    launch_c  = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          launch_c = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // start is deliberately ignored here
        if (cnt_q == CNT_W'(MUL_LAT)) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          launch_c = 1'b1;
          state_d  = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand and handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == WAIT);
      done_q  <= (state_d == DONE);
      if (launch_c) begin
        cnt_q <= '0;
        neg_q <= neg_c;
        mul_a <= mag_a_c;
        mul_b <= mag_b_c;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // HI/LO: product write takes priority over a coincident MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (capture_c) begin
      hi_q <= prod_c[63:32];
      lo_q <= prod_c[31:0];
    end else begin
      if (bus.hi_we) hi_q <= bus.wdata;
      if (bus.lo_we) lo_q <= bus.wdata;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed self-checking bench for mult_hilo_ctrl with a 6-stage multiplier model.
module tb_mult_hilo_ctrl;
  localparam int unsigned MUL_LAT = 6;

  logic        clk;
  logic        reset;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_z;
  logic [63:0] pipe [MUL_LAT];
  int          checks;
  int          errors;

  mult_hilo_if bus();

  mult_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_z(mul_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External unsigned multiplier: product of mul_a/mul_b appears MUL_LAT edges later.
  always @(posedge clk) begin
    pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_z = pipe[MUL_LAT-1];

  // Drive a start for one edge (E0); returns at the negedge just after E0.
  task automatic launch(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = sgn; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.hi !== 32'd0)   begin errors++; $display("FAIL rst_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0)   begin errors++; $display("FAIL rst_lo got %h exp 0", bus.lo); end
    checks++; if (mul_a !== 32'd0)    begin errors++; $display("FAIL rst_mul_a got %h exp 0", mul_a); end
    checks++; if (mul_b !== 32'd0)    begin errors++; $display("FAIL rst_mul_b got %h exp 0", mul_b); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL rst_busy_done got %b%b exp 00", bus.busy, bus.done); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_max;
    int nb;
    launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++; if (mul_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL multu_mul_a got %h exp ffffffff", mul_a); end
    checks++; if (mul_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL multu_mul_b got %h exp ffffffff", mul_b); end
    nb = 0;
    repeat (7) begin
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
    end
    checks++; if (nb != 7) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 7", nb); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1)
      begin errors++; $display("FAIL multu_done got busy=%b done=%b exp 0 1", bus.busy, bus.done); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b exp 0", bus.done); end
  endtask

  task automatic test_mult_neg;
    launch(1'b1, 32'hFFFFFFFD, 32'd5);
    checks++; if (mul_a !== 32'd3) begin errors++; $display("FAIL neg_mul_a got %h exp 3", mul_a); end
    checks++; if (mul_b !== 32'd5) begin errors++; $display("FAIL neg_mul_b got %h exp 5", mul_b); end
    repeat (6) @(negedge clk);
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL neg_early_lo got %h exp 00000001", bus.lo); end
    @(negedge clk);
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL neg_hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL neg_lo got %h exp fffffff1", bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_mult_min;
    launch(1'b1, 32'h80000000, 32'h80000000);
    checks++; if (mul_a !== 32'h80000000 || mul_b !== 32'h80000000)
      begin errors++; $display("FAIL min_mags got %h %h exp 80000000 80000000", mul_a, mul_b); end
    repeat (7) @(negedge clk);
    checks++; if (bus.hi !== 32'h40000000) begin errors++; $display("FAIL min_hi got %h exp 40000000", bus.hi); end
    checks++; if (bus.lo !== 32'h00000000) begin errors++; $display("FAIL min_lo got %h exp 0", bus.lo); end
    // Second multiply, with a stray start during WAIT that must be ignored.
    launch(1'b1, 32'h80000000, 32'd1);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (mul_a !== 32'h80000000 || mul_b !== 32'd1)
      begin errors++; $display("FAIL wait_start_ignored got %h %h exp 80000000 00000001", mul_a, mul_b); end
    repeat (5) @(negedge clk);
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL min1_hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL min1_lo got %h exp 80000000", bus.lo); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL min1_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back;
    launch(1'b0, 32'd7, 32'd6);
    repeat (7) @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.lo !== 32'd42 || bus.hi !== 32'd0)
      begin errors++; $display("FAIL b2b_first got done=%b hi=%h lo=%h exp 1 0 2a", bus.done, bus.hi, bus.lo); end
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      begin errors++; $display("FAIL b2b_rebusy got busy=%b done=%b exp 1 0", bus.busy, bus.done); end
    checks++; if (mul_a !== 32'd1 || mul_b !== 32'd1)
      begin errors++; $display("FAIL b2b_mags got %h %h exp 1 1", mul_a, mul_b); end
    repeat (7) @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd1)
      begin errors++; $display("FAIL b2b_second got done=%b hi=%h lo=%h exp 1 0 1", bus.done, bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo;
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h exp 12345678", bus.hi); end
    launch(1'b0, 32'd2, 32'd3);
    repeat (2) @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'h0000DEAD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++; if (bus.lo !== 32'h0000DEAD) begin errors++; $display("FAIL mtlo_wait got %h exp 0000dead", bus.lo); end
    repeat (3) @(negedge clk);
    checks++; if (bus.hi !== 32'h12345678 || bus.lo !== 32'h0000DEAD)
      begin errors++; $display("FAIL mtlo_hold got hi=%h lo=%h exp 12345678 0000dead", bus.hi, bus.lo); end
    bus.lo_we = 1'b1; bus.wdata = 32'h0000DEAD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd6 || bus.done !== 1'b1)
      begin errors++; $display("FAIL product_wins got hi=%h lo=%h done=%b exp 0 6 1", bus.hi, bus.lo, bus.done); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    int seen;
    launch(1'b0, 32'h0000FFFF, 32'h0000FFFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 ||
                  mul_a !== 32'd0 || mul_b !== 32'd0)
      begin errors++; $display("FAIL midrst_outputs got busy=%b done=%b hi=%h lo=%h ma=%h mb=%h exp all 0",
                               bus.busy, bus.done, bus.hi, bus.lo, mul_a, mul_b); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles exp 0", seen); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset;
    test_multu_max;
    test_mult_neg;
    test_mult_min;
    test_back_to_back;
    test_mthi_mtlo;
    test_reset_midflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_hilo_ctrl.md
# mult_hilo_ctrl

Sequencing and result stage for the CPU's MULT/MULTU instructions. It sits between the execute stage and the team's 6-stage pipelined unsigned 32x32 multiplier. It feeds operands to the multiplier, converts signed operands to magnitudes and back, and waits out the pipeline latency. It then writes the 64-bit product into the HI/LO architectural registers, with a busy/done handshake toward the CPU stall logic. The same block also owns MTHI/MTLO writes and the HI/LO read ports.

## Interface
- MUL_LAT, 6, clock edges from mul_a/mul_b update until mul_z holds the product (must be ≥1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  launch a multiply; sampled only in IDLE or DONE
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- a  in  32  multiplicand (rs)
- b  in  32  multiplier (rt)
- mul_a  out  32  operand to unsigned multiplier
- mul_b  out  32  operand to unsigned multiplier
- mul_z  in  64  unsigned product from multiplier
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  multiply in flight; CPU stalls any MFHI/MFLO/MULT while high
- done  out  1  one-cycle pulse: HI/LO just updated with a product
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, WAIT, DONE. Use a counter cnt that is ceil(log2(MUL_LAT+1)) bits wide.
- IDLE: busy=0, done=0. On start=1, do the following at the same edge:
  - mul_a ← (is_signed & a[31]) ? -a : a.
  - mul_b ← (is_signed & b[31]) ? -b : b.
  - neg ← is_signed & (a[31]^b[31]).
  - cnt ← 0.
  - state ← WAIT.
- Magnitude rule: -0x80000000 yields 0x80000000. This is correct as an unsigned 32-bit magnitude and needs no special case.
- WAIT: busy=1, done=0. cnt increments each edge. When cnt == MUL_LAT at an edge:
  - {hi,lo} ← neg ? (~mul_z + 1) : mul_z, using 64-bit two's-complement negation.
  - state ← DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - start=1 behaves as in IDLE: a back-to-back launch with no bubble.
  - Otherwise state ← IDLE.
- mul_a/mul_b hold their values until the next accepted start. They are not cleared on completion.
- start during WAIT is ignored. The CPU must not assert it, and the bench checks that it has no effect.
- MTHI/MTLO:
  - hi_we=1 writes hi ← wdata; lo_we=1 writes lo ← wdata.
  - Writes apply in any state, including WAIT.
  - If a write coincides with the product-write edge, the product wins. A write during WAIT is therefore lost when the product lands, matching MIPS "undefined" with a deterministic choice.
- start together with hi_we/lo_we in IDLE: the register write applies and the multiply launches. The result later overwrites both HI and LO.
- Reset (asserted low, asynchronous), in any state including mid-WAIT:
  - state=IDLE, cnt=0, neg=0.
  - mul_a=0, mul_b=0, hi=0, lo=0, busy=0, done=0.
  - The in-flight product is discarded. Stale multiplier pipeline contents are never captured, because capture occurs only in WAIT after a fresh launch.

## Timing
- Let E0 be the edge that samples start. mul_a/mul_b are valid after E0, and busy rises after E0.
- mul_z is valid after E0+MUL_LAT.
- hi/lo update at edge E0+MUL_LAT+1; with the default this is E0+7.
- done is high in the cycle after that edge. busy is high for exactly MUL_LAT+1 cycles.
- Minimum start-to-start spacing is MUL_LAT+2 cycles, via the launch from DONE.
- busy and done are registered or decoded from the state register only. They have no combinational path from start.
- hi/lo are registered outputs. A read in the DONE cycle returns the new product.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF. Required: busy for 7 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001, mul_a=mul_b=0xFFFFFFFF after E0.
- MULT a=0xFFFFFFFD (-3), b=5. Required: mul_a=3, mul_b=5, then hi=0xFFFFFFFF, lo=0xFFFFFFF1 at E0+7.
- MULT a=b=0x80000000. Required: mul_a=mul_b=0x80000000, hi=0x40000000, lo=0x00000000. Then MULT a=0x80000000, b=1. Required: hi=0xFFFFFFFF, lo=0x80000000.
- Back-to-back: MULTU 7×6, then a second start (MULT 0xFFFFFFFF×0xFFFFFFFF) in the DONE cycle. Required:
  - First done leaves lo=42.
  - busy re-rises with no idle cycle.
  - Second done leaves hi=0, lo=1.
- MTHI 0x12345678 in IDLE, which is visible the next cycle. Then MULTU 2×3, with MTLO 0xDEAD at E0+3 and again at E0+7. Required: lo=0xDEAD at E0+4, then hi=0, lo=6 after E0+7 (the product wins).
- Start MULTU 0xFFFF×0xFFFF, assert reset at E0+3 for 1 cycle, and drive no new start. Required: all outputs 0 immediately, stay in IDLE, and no done pulse afterward.
